int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue_pkg.sv | 42 ++++
 rtl/int_issue_queue_if.sv | 63 ++++++
 rtl/int_issue_queue_iq_entry.sv | 80 ++++++++
 rtl/int_issue_queue.sv | 107 ++++++++++
 tb/tb_int_issue_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared dispatcher package: RV32 opcode constants, default widths and the
// issue-queue entry layout used by the dispatcher and the integer queue.
package int_issue_queue_pkg;

   localparam int TAG_W_DEF  = 6;
   localparam int DATA_W_DEF = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // Decoded control fields that travel with an instruction unchanged.
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic       branch;
      logic       jmp;
      logic       jalr;
   } iq_ctrl_t;

   // Full entry layout at the default widths (dispatcher-side view).
   typedef struct packed {
      logic                  valid;
      logic                  rs1_rdy;
      logic [TAG_W_DEF-1:0]  rs1_tag;
      logic [DATA_W_DEF-1:0] rs1_val;
      logic                  rs2_rdy;
      logic [TAG_W_DEF-1:0]  rs2_tag;
      logic [DATA_W_DEF-1:0] rs2_val;
      iq_ctrl_t              ctrl;
      logic [DATA_W_DEF-1:0] imm;
      logic [TAG_W_DEF-1:0]  rd_tag;
   } iq_entry_t;

endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch / CDB / flush / issue bundle between dispatcher, CDB and the
// integer issue queue. master = environment side, slave = the queue.
interface int_issue_queue_if
   import int_issue_queue_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              dispatch_en;
   logic [6:0]        disp_opcode;
   logic [2:0]        disp_funct3;
   logic [6:0]        disp_funct7;
   logic              disp_branch;
   logic              disp_jmp;
   logic              disp_jalr;
   logic [DATA_W-1:0] disp_imm;
   logic [TAG_W-1:0]  disp_rs1_tag;
   logic [TAG_W-1:0]  disp_rs2_tag;
   logic [TAG_W-1:0]  disp_rd_tag;
   logic [DATA_W-1:0] disp_rs1_val;
   logic [DATA_W-1:0] disp_rs2_val;
   logic              disp_rs1_rdy;
   logic              disp_rs2_rdy;
   logic              queue_full;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              flush;

   logic              issue_ready;
   logic              issue_valid;
   logic [6:0]        issue_opcode;
   logic [2:0]        issue_funct3;
   logic [6:0]        issue_funct7;
   logic              issue_branch;
   logic              issue_jmp;
   logic              issue_jalr;
   logic [DATA_W-1:0] issue_imm;
   logic [DATA_W-1:0] issue_rs1_val;
   logic [DATA_W-1:0] issue_rs2_val;
   logic [TAG_W-1:0]  issue_rd_tag;

   modport master (
      output dispatch_en, disp_opcode, disp_funct3, disp_funct7, disp_branch,
             disp_jmp, disp_jalr, disp_imm, disp_rs1_tag, disp_rs2_tag,
             disp_rd_tag, disp_rs1_val, disp_rs2_val, disp_rs1_rdy,
             disp_rs2_rdy, cdb_valid, cdb_tag, cdb_data, flush, issue_ready,
      input  queue_full, issue_valid, issue_opcode, issue_funct3, issue_funct7,
             issue_branch, issue_jmp, issue_jalr, issue_imm, issue_rs1_val,
             issue_rs2_val, issue_rd_tag
   );

   modport slave (
      input  dispatch_en, disp_opcode, disp_funct3, disp_funct7, disp_branch,
             disp_jmp, disp_jalr, disp_imm, disp_rs1_tag, disp_rs2_tag,
             disp_rd_tag, disp_rs1_val, disp_rs2_val, disp_rs1_rdy,
             disp_rs2_rdy, cdb_valid, cdb_tag, cdb_data, flush, issue_ready,
      output queue_full, issue_valid, issue_opcode, issue_funct3, issue_funct7,
             issue_branch, issue_jmp, issue_jalr, issue_imm, issue_rs1_val,
             issue_rs2_val, issue_rd_tag
   );
endinterface

// File: rtl/int_issue_queue_iq_entry.sv
// One issue-queue slot: holds an instruction and its two operands, and
// snoops the CDB both at write time (bypass) and while waiting (wakeup).
module iq_entry
   import int_issue_queue_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr,
   input  logic              pop,
   input  iq_ctrl_t          disp_ctrl,
   input  logic [DATA_W-1:0] disp_imm,
   input  logic [TAG_W-1:0]  disp_rd_tag,
   input  logic [TAG_W-1:0]  disp_rs1_tag,
   input  logic [DATA_W-1:0] disp_rs1_val,
   input  logic              disp_rs1_rdy,
   input  logic [TAG_W-1:0]  disp_rs2_tag,
   input  logic [DATA_W-1:0] disp_rs2_val,
   input  logic              disp_rs2_rdy,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              valid,
   output logic              rs1_rdy,
   output logic              rs2_rdy,
   output logic [DATA_W-1:0] rs1_val,
   output logic [DATA_W-1:0] rs2_val,
   output iq_ctrl_t          ctrl,
   output logic [DATA_W-1:0] imm,
   output logic [TAG_W-1:0]  rd_tag
);
   logic [TAG_W-1:0] rs1_tag;
   logic [TAG_W-1:0] rs2_tag;
   logic             rs1_bypass;
   logic             rs2_bypass;
   logic             rs1_wake;
   logic             rs2_wake;

   // A producer broadcasting in the same cycle as dispatch would otherwise be missed.
   assign rs1_bypass = !disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_tag);
   assign rs2_bypass = !disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_tag);
   assign rs1_wake   = valid && !rs1_rdy && cdb_valid && (rs1_tag == cdb_tag);
   assign rs2_wake   = valid && !rs2_rdy && cdb_valid && (rs2_tag == cdb_tag);

   // Slot occupancy and operand-ready bits; the only state that needs reset.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         valid   <= 1'b0;
         rs1_rdy <= 1'b0;
         rs2_rdy <= 1'b0;
      end else if (wr) begin
         valid   <= 1'b1;
         rs1_rdy <= disp_rs1_rdy | rs1_bypass;
         rs2_rdy <= disp_rs2_rdy | rs2_bypass;
      end else begin
         if (pop)      valid   <= 1'b0;
         if (rs1_wake) rs1_rdy <= 1'b1;
         if (rs2_wake) rs2_rdy <= 1'b1;
      end
   end

   // Payload capture; meaningless while the slot is invalid, so never reset.
   always_ff @(posedge clk) begin
      if (wr) begin
         ctrl    <= disp_ctrl;
         imm     <= disp_imm;
         rd_tag  <= disp_rd_tag;
         rs1_tag <= disp_rs1_tag;
         rs2_tag <= disp_rs2_tag;
         rs1_val <= rs1_bypass ? cdb_data : disp_rs1_val;
         rs2_val <= rs2_bypass ? cdb_data : disp_rs2_val;
      end else begin
         if (rs1_wake) rs1_val <= cdb_data;
         if (rs2_wake) rs2_val <= cdb_data;
      end
   end
endmodule

// File: rtl/int_issue_queue.sv
// In-order integer issue queue: circular buffer of iq_entry slots, issuing
// only from the head once both of its operands are ready.
module int_issue_queue
   import int_issue_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   int_issue_queue_if.slave    bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              dispatch_go;
   logic              issue_go;
   iq_ctrl_t          disp_ctrl;

   logic [DEPTH-1:0]  e_valid;
   logic [DEPTH-1:0]  e_rs1_rdy;
   logic [DEPTH-1:0]  e_rs2_rdy;
   logic [DATA_W-1:0] e_rs1_val [DEPTH];
   logic [DATA_W-1:0] e_rs2_val [DEPTH];
   logic [DATA_W-1:0] e_imm     [DEPTH];
   logic [TAG_W-1:0]  e_rd_tag  [DEPTH];
   iq_ctrl_t          e_ctrl    [DEPTH];
   iq_ctrl_t          head_ctrl;

   assign disp_ctrl = '{opcode: bus.disp_opcode, funct3: bus.disp_funct3,
                        funct7: bus.disp_funct7, branch: bus.disp_branch,
                        jmp: bus.disp_jmp, jalr: bus.disp_jalr};

   // Full is taken from the registered count, so a same-cycle issue cannot admit a dispatch.
   assign bus.queue_full = (count == CNT_W'(DEPTH));
   assign dispatch_go    = bus.dispatch_en && !bus.queue_full && !bus.flush;
   assign issue_go       = bus.issue_valid && bus.issue_ready && !bus.flush;

   // Issue depends on registered slot state only; rst_n gating keeps it quiet during reset.
   assign bus.issue_valid = rst_n && e_valid[rd_ptr] && e_rs1_rdy[rd_ptr] && e_rs2_rdy[rd_ptr];

   assign head_ctrl         = e_ctrl[rd_ptr];
   assign bus.issue_opcode  = head_ctrl.opcode;
   assign bus.issue_funct3  = head_ctrl.funct3;
   assign bus.issue_funct7  = head_ctrl.funct7;
   assign bus.issue_branch  = head_ctrl.branch;
   assign bus.issue_jmp     = head_ctrl.jmp;
   assign bus.issue_jalr    = head_ctrl.jalr;
   assign bus.issue_imm     = e_imm[rd_ptr];
   assign bus.issue_rs1_val = e_rs1_val[rd_ptr];
   assign bus.issue_rs2_val = e_rs2_val[rd_ptr];
   assign bus.issue_rd_tag  = e_rd_tag[rd_ptr];

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      iq_entry #(
         .TAG_W  (TAG_W),
         .DATA_W (DATA_W)
      ) u_entry (
         .clk          (clk),
         .rst_n        (rst_n),
         .clr          (bus.flush),
         .wr           (dispatch_go && (wr_ptr == PTR_W'(g))),
         .pop          (issue_go && (rd_ptr == PTR_W'(g))),
         .disp_ctrl    (disp_ctrl),
         .disp_imm     (bus.disp_imm),
         .disp_rd_tag  (bus.disp_rd_tag),
         .disp_rs1_tag (bus.disp_rs1_tag),
         .disp_rs1_val (bus.disp_rs1_val),
         .disp_rs1_rdy (bus.disp_rs1_rdy),
         .disp_rs2_tag (bus.disp_rs2_tag),
         .disp_rs2_val (bus.disp_rs2_val),
         .disp_rs2_rdy (bus.disp_rs2_rdy),
         .cdb_valid    (bus.cdb_valid),
         .cdb_tag      (bus.cdb_tag),
         .cdb_data     (bus.cdb_data),
         .valid        (e_valid[g]),
         .rs1_rdy      (e_rs1_rdy[g]),
         .rs2_rdy      (e_rs2_rdy[g]),
         .rs1_val      (e_rs1_val[g]),
         .rs2_val      (e_rs2_val[g]),
         .ctrl         (e_ctrl[g]),
         .imm          (e_imm[g]),
         .rd_tag       (e_rd_tag[g])
      );
   end

   // Pointers wrap naturally at DEPTH (power of two); flush overrides dispatch and issue.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (dispatch_go) wr_ptr <= wr_ptr + PTR_W'(1);
         if (issue_go)    rd_ptr <= rd_ptr + PTR_W'(1);
         case ({dispatch_go, issue_go})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: inputs change 1 ns after the rising
// edge and outputs are sampled there, away from the active edge.
module tb_int_issue_queue;
   import int_issue_queue_pkg::*;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;
   int   model_q [$];

   int_issue_queue_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   int_issue_queue #(.DEPTH(4), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [TAG_W-1:0] rd,
                           input logic r1rdy, input logic [TAG_W-1:0] r1tag, input logic [DATA_W-1:0] r1val,
                           input logic r2rdy, input logic [TAG_W-1:0] r2tag, input logic [DATA_W-1:0] r2val);
      bus.dispatch_en  = 1'b1;
      bus.disp_opcode  = OP_REG;
      bus.disp_funct3  = 3'd0;
      bus.disp_funct7  = 7'd0;
      bus.disp_branch  = 1'b0;
      bus.disp_jmp     = 1'b0;
      bus.disp_jalr    = 1'b0;
      bus.disp_imm     = 32'h0000_0100 + DATA_W'(rd);
      bus.disp_rd_tag  = rd;
      bus.disp_rs1_rdy = r1rdy;
      bus.disp_rs1_tag = r1tag;
      bus.disp_rs1_val = r1val;
      bus.disp_rs2_rdy = r2rdy;
      bus.disp_rs2_tag = r2tag;
      bus.disp_rs2_val = r2val;
   endtask

   task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      bus.cdb_valid = v;
      bus.cdb_tag   = t;
      bus.cdb_data  = d;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.flush       = 1'b0;
      bus.issue_ready = 1'b0;
      cdb(1'b0, '0, '0);
      set_disp('0, 1'b1, '0, '0, 1'b1, '0, '0);
      bus.dispatch_en = 1'b0;
      #1;
      step();
      step();
      rst_n = 1'b1;
      check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      check("rst_queue_full", 64'(bus.queue_full), 64'd0);
      check("rst_count", 64'(dut.count), 64'd0);

      // ADD with both operands ready
      bus.issue_ready = 1'b1;
      set_disp(6'd9, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7);
      step();
      bus.dispatch_en = 1'b0;
      check("add_issue_valid", 64'(bus.issue_valid), 64'd1);
      check("add_rs1_val", 64'(bus.issue_rs1_val), 64'd5);
      check("add_rs2_val", 64'(bus.issue_rs2_val), 64'd7);
      check("add_rd_tag", 64'(bus.issue_rd_tag), 64'd9);
      check("add_opcode", 64'(bus.issue_opcode), 64'h33);
      check("add_imm", 64'(bus.issue_imm), 64'h109);
      step();
      check("add_count_after", 64'(dut.count), 64'd0);
      check("add_drained", 64'(bus.issue_valid), 64'd0);

      // CDB wakeup of the head
      set_disp(6'd13, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd1);
      step();
      bus.dispatch_en = 1'b0;
      check("wake_wait0", 64'(bus.issue_valid), 64'd0);
      step();
      check("wake_wait1", 64'(bus.issue_valid), 64'd0);
      cdb(1'b1, 6'd12, 32'hDEAD);
      #1;
      check("wake_no_comb_path", 64'(bus.issue_valid), 64'd0);
      step();
      cdb(1'b0, '0, '0);
      check("wake_issue_valid", 64'(bus.issue_valid), 64'd1);
      check("wake_rs1_val", 64'(bus.issue_rs1_val), 64'hDEAD);
      step();
      check("wake_count_after", 64'(dut.count), 64'd0);

      // Fill, overflow, full-with-issue, pointer wrap
      bus.issue_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         set_disp(TAG_W'(i), 1'b1, '0, 32'(i), 1'b1, '0, 32'(i));
         step();
      end
      check("full_flag", 64'(bus.queue_full), 64'd1);
      check("full_count", 64'(dut.count), 64'd4);
      set_disp(6'd5, 1'b1, '0, 32'd5, 1'b1, '0, 32'd5);
      step();
      check("full_ignored_count", 64'(dut.count), 64'd4);
      check("full_stable_head", 64'(bus.issue_rd_tag), 64'd1);
      bus.issue_ready = 1'b1;
      step();
      check("full_issue_count", 64'(dut.count), 64'd3);
      check("full_cleared", 64'(bus.queue_full), 64'd0);
      model_q = '{2, 3, 4};
      for (int i = 0; i < 10; i++) begin
         check("wrap_head", 64'(bus.issue_rd_tag), 64'(model_q[0]));
         set_disp(TAG_W'(10 + i), 1'b1, '0, 32'(i), 1'b1, '0, 32'(i));
         step();
         void'(model_q.pop_front());
         model_q.push_back(10 + i);
      end
      check("wrap_count", 64'(dut.count), 64'd3);
      bus.dispatch_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("drain_head", 64'(bus.issue_rd_tag), 64'(model_q[0]));
         step();
         void'(model_q.pop_front());
      end
      check("drain_count", 64'(dut.count), 64'd0);

      // Non-ready head blocks a ready younger entry
      set_disp(6'd30, 1'b0, 6'd20, 32'd0, 1'b1, '0, 32'd2);
      step();
      set_disp(6'd31, 1'b1, '0, 32'd3, 1'b1, '0, 32'd4);
      step();
      bus.dispatch_en = 1'b0;
      check("order_blocked0", 64'(bus.issue_valid), 64'd0);
      step();
      check("order_blocked1", 64'(bus.issue_valid), 64'd0);
      cdb(1'b1, 6'd20, 32'h111);
      step();
      cdb(1'b0, '0, '0);
      check("order_first_valid", 64'(bus.issue_valid), 64'd1);
      check("order_first_tag", 64'(bus.issue_rd_tag), 64'd30);
      check("order_first_rs1", 64'(bus.issue_rs1_val), 64'h111);
      step();
      check("order_second_tag", 64'(bus.issue_rd_tag), 64'd31);
      step();
      check("order_count", 64'(dut.count), 64'd0);

      // Both operands wake in the same broadcast
      set_disp(6'd40, 1'b0, 6'd7, 32'd0, 1'b0, 6'd7, 32'd0);
      step();
      bus.dispatch_en = 1'b0;
      cdb(1'b1, 6'd7, 32'h5);
      step();
      cdb(1'b0, '0, '0);
      check("dual_valid", 64'(bus.issue_valid), 64'd1);
      check("dual_rs1", 64'(bus.issue_rs1_val), 64'h5);
      check("dual_rs2", 64'(bus.issue_rs2_val), 64'h5);
      step();

      // Dispatch-time CDB bypass
      bus.issue_ready = 1'b0;
      set_disp(6'd41, 1'b1, '0, 32'd1, 1'b0, 6'd3, 32'h0BAD);
      cdb(1'b1, 6'd3, 32'h42);
      step();
      bus.dispatch_en = 1'b0;
      cdb(1'b0, '0, '0);
      check("bypass_valid", 64'(bus.issue_valid), 64'd1);
      check("bypass_rs2", 64'(bus.issue_rs2_val), 64'h42);
      bus.issue_ready = 1'b1;
      step();
      check("bypass_count", 64'(dut.count), 64'd0);

      // Flush with dispatch pending
      bus.issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_disp(TAG_W'(50 + i), 1'b1, '0, '0, 1'b1, '0, '0);
         step();
      end
      check("flush_pre_count", 64'(dut.count), 64'd3);
      bus.issue_ready = 1'b1;
      bus.flush = 1'b1;
      set_disp(6'd60, 1'b1, '0, '0, 1'b1, '0, '0);
      step();
      bus.flush = 1'b0;
      bus.dispatch_en = 1'b0;
      check("flush_count", 64'(dut.count), 64'd0);
      check("flush_issue_valid", 64'(bus.issue_valid), 64'd0);
      step();
      check("flush_discarded", 64'(bus.issue_valid), 64'd0);

      // Reset with dispatch pending
      bus.issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_disp(TAG_W'(50 + i), 1'b1, '0, '0, 1'b1, '0, '0);
         step();
      end
      check("rstm_pre_valid", 64'(bus.issue_valid), 64'd1);
      rst_n = 1'b0;
      set_disp(6'd61, 1'b1, '0, '0, 1'b1, '0, '0);
      #1;
      check("rstm_during", 64'(bus.issue_valid), 64'd0);
      step();
      rst_n = 1'b1;
      bus.dispatch_en = 1'b0;
      check("rstm_count", 64'(dut.count), 64'd0);
      check("rstm_issue_valid", 64'(bus.issue_valid), 64'd0);
      step();
      check("rstm_discarded", 64'(bus.issue_valid), 64'd0);

      // Queue usable again after reset
      set_disp(6'd62, 1'b1, '0, 32'd8, 1'b1, '0, 32'd9);
      step();
      bus.dispatch_en = 1'b0;
      check("post_rst_tag", 64'(bus.issue_rd_tag), 64'd62);
      check("post_rst_valid", 64'(bus.issue_valid), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
